// File: rtl/fp16_pkg.sv
// Shared constants, state encodings and FSM state type for the binary16
// sequential multiplier.
package fp16_pkg;

  localparam int EXP_W      = 5;
  localparam int MAN_W      = 10;
  localparam int BIAS       = 15;
  localparam int MUL_CYCLES = 11;

  localparam logic [15:0]      QNAN    = 16'h7E00;
  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;

  localparam logic [2:0] ENC_IDLE   = 3'd0;
  localparam logic [2:0] ENC_UNPACK = 3'd1;
  localparam logic [2:0] ENC_MUL    = 3'd2;
  localparam logic [2:0] ENC_NORM   = 3'd3;
  localparam logic [2:0] ENC_ROUND  = 3'd4;
  localparam logic [2:0] ENC_DONE   = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ENC_IDLE,
    UNPACK = ENC_UNPACK,
    MUL    = ENC_MUL,
    NORM   = ENC_NORM,
    ROUND  = ENC_ROUND,
    DONE   = ENC_DONE
  } state_t;

endpackage

// File: rtl/fp16_round_pack.sv
// Combinational round-to-nearest-even and pack of a normalized significand
// into binary16, with flush-to-zero and saturation to infinity.
module fp16_round_pack
  import fp16_pkg::*;
(
  input  logic              sign,
  input  logic signed [6:0] exp_in,
  input  logic [MAN_W:0]    sig,
  input  logic              guard,
  input  logic              rnd,
  input  logic              sticky,
  output logic [15:0]       result,
  output logic              overflow,
  output logic              underflow
);

  logic              round_up;
  logic [MAN_W+1:0]  sum;
  logic signed [7:0] exp_f;
  logic [MAN_W-1:0]  frac;

  always_comb begin
    round_up  = guard & (rnd | sticky | sig[0]);
    sum       = {1'b0, sig} + {{(MAN_W+1){1'b0}}, round_up};
    // A carry out of the significand only happens from all-ones, leaving 1.0
    exp_f     = {exp_in[6], exp_in} + {7'd0, sum[MAN_W+1]};
    frac      = sum[MAN_W+1] ? sum[MAN_W:1] : sum[MAN_W-1:0];
    result    = {sign, exp_f[EXP_W-1:0], frac};
    overflow  = 1'b0;
    underflow = 1'b0;
    if (exp_f >= 8'sd31) begin
      result   = {sign, EXP_MAX, {MAN_W{1'b0}}};
      overflow = 1'b1;
    end else if (exp_f <= 8'sd0) begin
      result    = {sign, 15'h0000};
      underflow = 1'b1;
    end
  end

endmodule

// File: rtl/fp16_seq_mul.sv
// Multi-cycle binary16 multiplier: shift-add significand product, one
// multiplier bit per cycle, with a start/done handshake.
//
// state  | meaning
// IDLE   | waiting for start; result held
// UNPACK | decode operands, resolve special cases
// MUL    | 11 shift-add steps of the 11x11 significand product
// NORM   | normalize product, form guard/round/sticky
// ROUND  | round-to-nearest-even and pack
// DONE   | one-cycle done pulse
module fp16_seq_mul
  import fp16_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] result,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  state_t state, state_nxt;

  logic [15:0]       op_a, op_b;
  logic              sign_q;
  logic signed [6:0] exp_q;
  logic [21:0]       mcand, acc;
  logic [MAN_W:0]    mplier;
  logic [3:0]        cnt;
  logic [MAN_W:0]    norm_sig;
  logic              g_q, r_q, s_q;

  logic [EXP_W-1:0]  ea, eb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
  logic              special, spec_inv;
  logic [15:0]       spec_res;
  logic signed [6:0] exp_sum;

  logic [15:0]       rp_result;
  logic              rp_ovf, rp_unf;

  always_comb begin
    ea       = op_a[14:10];
    eb       = op_b[14:10];
    a_nan    = (ea == EXP_MAX) && (op_a[9:0] != '0);
    b_nan    = (eb == EXP_MAX) && (op_b[9:0] != '0);
    a_inf    = (ea == EXP_MAX) && (op_a[9:0] == '0);
    b_inf    = (eb == EXP_MAX) && (op_b[9:0] == '0);
    // Subnormal operands collapse to zero
    a_zero   = (ea == '0);
    b_zero   = (eb == '0);
    exp_sum  = $signed({2'b00, ea} + {2'b00, eb} - 7'(BIAS));
    special  = 1'b1;
    spec_inv = 1'b0;
    spec_res = QNAN;
    if (a_nan || b_nan) begin
      spec_res = QNAN;
    end else if ((a_inf && b_zero) || (b_inf && a_zero)) begin
      spec_res = QNAN;
      spec_inv = 1'b1;
    end else if (a_inf || b_inf) begin
      spec_res = {op_a[15] ^ op_b[15], EXP_MAX, {MAN_W{1'b0}}};
    end else if (a_zero || b_zero) begin
      spec_res = {op_a[15] ^ op_b[15], 15'h0000};
    end else begin
      special = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = UNPACK;
      UNPACK:  state_nxt = special ? DONE : MUL;
      MUL:     if (cnt == 4'(MUL_CYCLES - 1)) state_nxt = NORM;
      NORM:    state_nxt = ROUND;
      ROUND:   state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a      <= '0;
      op_b      <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      mcand     <= '0;
      mplier    <= '0;
      acc       <= '0;
      cnt       <= '0;
      norm_sig  <= '0;
      g_q       <= 1'b0;
      r_q       <= 1'b0;
      s_q       <= 1'b0;
      result    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
      invalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_a      <= a;
          op_b      <= b;
          overflow  <= 1'b0;
          underflow <= 1'b0;
          invalid   <= 1'b0;
        end
        UNPACK: begin
          sign_q <= op_a[15] ^ op_b[15];
          exp_q  <= exp_sum;
          mcand  <= {11'd0, 1'b1, op_a[9:0]};
          mplier <= {1'b1, op_b[9:0]};
          acc    <= '0;
          cnt    <= '0;
          if (special) begin
            result  <= spec_res;
            invalid <= spec_inv;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + 4'd1;
        end
        NORM: begin
          // Product of two [1,2) significands lies in [1,4)
          if (acc[21]) begin
            norm_sig <= acc[21:11];
            g_q      <= acc[10];
            r_q      <= acc[9];
            s_q      <= |acc[8:0];
            exp_q    <= exp_q + 7'sd1;
          end else begin
            norm_sig <= acc[20:10];
            g_q      <= acc[9];
            r_q      <= acc[8];
            s_q      <= |acc[7:0];
          end
        end
        ROUND: begin
          result    <= rp_result;
          overflow  <= rp_ovf;
          underflow <= rp_unf;
        end
        default: ;
      endcase
    end
  end

  fp16_round_pack u_round_pack (
    .sign      (sign_q),
    .exp_in    (exp_q),
    .sig       (norm_sig),
    .guard     (g_q),
    .rnd       (r_q),
    .sticky    (s_q),
    .result    (rp_result),
    .overflow  (rp_ovf),
    .underflow (rp_unf)
  );

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
